mem_port_arbiter: RTL and testbench

Arbitrates the multicycle CPU's single unified memory port between two requesters: port 0 is the CPU memory interface, port 1 is the external loader/debug interface. It serialises whole transactions (issue, fixed-latency wait, acknowledge) using a round-robin policy. It sits between the CPU control path and the memory, so the CPU's memory-access states stall until their transaction is acknowledged.

---
 rtl/mem_port_arbiter_if.sv | 28 ++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the unified memory port.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [1:0]    gnt;
  logic          busy;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, gnt, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, gnt, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising whole fixed-latency transactions from the CPU (port 0)
// and the loader/debug port (port 1) onto the single unified memory port.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;
  localparam logic [3:0] LAT   = 4'(MEM_LAT);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          last, owner, pick;
  logic [1:0]    gnt_q;
  logic          busy_q, ack0_q, ack1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          own_we;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata;

  // A lone requester wins outright; on a tie the port not granted last time wins.
  always_comb begin
    pick = bus.req1;
    if (bus.req0 && bus.req1) pick = ~last;
  end

  always_comb begin
    own_we    = owner ? bus.we1    : bus.we0;
    own_addr  = owner ? bus.addr1  : bus.addr0;
    own_wdata = owner ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      owner    <= 1'b0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner  <= pick;
            last   <= pick;
            gnt_q  <= {pick, ~pick};
            busy_q <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= 4'd1;
          state <= WAIT;
        end
        WAIT: begin
          // mem_rdata is valid in the cycle where cnt reaches the latency
          if (cnt == LAT) begin
            state <= ACK;
            if (owner) begin
              ack1_q <= 1'b1;
              if (!own_we) rdata1_q <= bus.mem_rdata;
            end else begin
              ack0_q <= 1'b1;
              if (!own_we) rdata0_q <= bus.mem_rdata;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ACK: begin
          state  <= IDLE;
          gnt_q  <= '0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = (state == ISSUE);
  assign bus.mem_we    = (state == ISSUE) && own_we;
  assign bus.mem_addr  = own_addr;
  assign bus.mem_wdata = own_wdata;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed timing sequences (latency 2 and 15)
// and random two-port traffic against a transaction-schedule reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LA = 2;
  localparam int LB = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) ba ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bb ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LA)) dut_a (.clk(clk), .rst(rst), .bus(ba));
  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LB)) dut_b (.clk(clk), .rst(rst), .bus(bb));

  // Memory responders: read data is valid only in the cycle MEM_LAT after mem_en.
  logic [DW-1:0] mem_a [256] = '{default: '0};
  logic [DW-1:0] mem_b [256] = '{default: '0};
  logic          pend_a = 1'b0, pend_b = 1'b0;
  int            cd_a = 0, cd_b = 0;
  logic [DW-1:0] val_a = '0, val_b = '0;

  always @(posedge clk) begin
    if (ba.mem_en && ba.mem_we) mem_a[ba.mem_addr[7:0]] <= ba.mem_wdata;
    if (ba.mem_en && !ba.mem_we) begin
      pend_a <= 1'b1; val_a <= mem_a[ba.mem_addr[7:0]]; cd_a <= LA - 1;
    end else if (pend_a) begin
      if (cd_a == 0) pend_a <= 1'b0; else cd_a <= cd_a - 1;
    end
  end

  always @(posedge clk) begin
    if (bb.mem_en && bb.mem_we) mem_b[bb.mem_addr[7:0]] <= bb.mem_wdata;
    if (bb.mem_en && !bb.mem_we) begin
      pend_b <= 1'b1; val_b <= mem_b[bb.mem_addr[7:0]]; cd_b <= LB - 1;
    end else if (pend_b) begin
      if (cd_b == 0) pend_b <= 1'b0; else cd_b <= cd_b - 1;
    end
  end

  assign ba.mem_rdata = (pend_a && cd_a == 0) ? val_a : 32'hBADBAD00;
  assign bb.mem_rdata = (pend_b && cd_b == 0) ? val_b : 32'hBADBAD00;

  typedef struct packed {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    int          first, second;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drv_a(input int p, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    if (p == 0) begin ba.req0 = r; ba.we0 = w; ba.addr0 = a; ba.wdata0 = d; end
    else        begin ba.req1 = r; ba.we1 = w; ba.addr1 = a; ba.wdata1 = d; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv_a(0, 1'b0, 1'b0, '0, '0);
    drv_a(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 50 && ba.busy !== 1'b0; i++) @(negedge clk);
    chk("idle_wait", ba.busy, 1'b0);
  endtask

  // Latency-15 transaction on dut_b port 0: ack exactly 17 cycles after the request cycle.
  task automatic seq_b(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd);
    chk("b_idle", bb.busy, 1'b0);
    bb.req0 = 1'b1; bb.we0 = w; bb.addr0 = a; bb.wdata0 = d;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      chk("b_mem_en", bb.mem_en, k == 1);
      chk("b_ack0", bb.ack0, k == LB + 2);
      chk("b_ack1", bb.ack1, 1'b0);
      if (k == LB + 2) begin
        chk("b_rdata0", bb.rdata0, exp_rd);
        bb.req0 = 1'b0;
      end
      if (k == LB + 3) chk("b_busy_end", bb.busy, 1'b0);
    end
  endtask

  // Random-phase state: requester intent plus the arbiter's transaction schedule.
  logic        pr [2], pwe [2];
  logic [31:0] pad [2], pwd [2], rref [2];
  logic [31:0] refmem [16];
  logic        m_act, m_own, m_last, en_exp, ack_exp, inx, just;
  int          m_d, m_ni;
  int          n, seq [4], cyc [4];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,  32'hDEADBEEF, 32'h0,        0, -1, 32'h0,        32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h20, 32'h0,        32'h0000CAFE, 1, -1, 32'h0,        32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h10, 32'h0,        32'h0,        0,  1, 32'h0000CAFE, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h10, 32'h11111111, 32'h0,        0,  1, 32'h0000CAFE, 32'h11111111};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h20, 32'h0,        32'h0,        1, -1, 32'h0000CAFE, 32'h0000CAFE};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h20, 32'h0,        32'h22222222, 0,  1, 32'h11111111, 32'h0000CAFE};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0,  32'h0,        32'h0,        0, -1, 32'h22222222, 32'h0000CAFE};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h20, 32'h0,        32'h0,        1,  0, 32'h11111111, 32'h22222222};

    drv_a(0, 1'b0, 1'b0, '0, '0);
    drv_a(1, 1'b0, 1'b0, '0, '0);
    bb.req0 = 1'b0; bb.we0 = 1'b0; bb.addr0 = '0; bb.wdata0 = '0;
    bb.req1 = 1'b0; bb.we1 = 1'b0; bb.addr1 = '0; bb.wdata1 = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", ba.gnt, 2'b00);
    chk("rst_busy", ba.busy, 1'b0);
    chk("rst_ack0", ba.ack0, 1'b0);
    chk("rst_ack1", ba.ack1, 1'b0);
    chk("rst_mem_en", ba.mem_en, 1'b0);
    chk("rst_mem_we", ba.mem_we, 1'b0);
    chk("rst_rdata0", ba.rdata0, 32'h0);
    chk("rst_rdata1", ba.rdata1, 32'h0);
    chk("rst_b_gnt", bb.gnt, 2'b00);
    rst = 1'b0;

    // contention right after reset: strict alternation starting with port 0
    drv_a(0, 1'b1, 1'b0, 32'h10, '0);
    drv_a(1, 1'b1, 1'b0, 32'h20, '0);
    n = 0;
    for (int i = 0; i < 4; i++) begin seq[i] = -1; cyc[i] = -1; end
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(negedge clk);
      if (ba.ack0 && n < 4) begin seq[n] = 0; cyc[n] = k; n++; end
      if (ba.ack1 && n < 4) begin seq[n] = 1; cyc[n] = k; n++; end
    end
    drv_a(0, 1'b0, 1'b0, '0, '0);
    drv_a(1, 1'b0, 1'b0, '0, '0);
    chk("cont_count", n, 4);
    chk("cont_first_cyc", cyc[0], LA + 2);
    for (int i = 0; i < 4; i++) chk("cont_order", seq[i], i % 2);
    for (int i = 1; i < 4; i++) chk("cont_spacing", cyc[i] - cyc[i-1], LA + 3);

    // vector table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wait_idle_a();
      drv_a(0, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0);
      drv_a(1, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      n = 0; seq[0] = -1; seq[1] = -1;
      for (int k = 1; k <= 30 && n < int'(tbl[i].r0) + int'(tbl[i].r1); k++) begin
        @(negedge clk);
        if (ba.mem_en && n == 0)
          chk("tbl_addr", ba.mem_addr, (tbl[i].first == 1) ? tbl[i].a1 : tbl[i].a0);
        if (ba.ack0) begin if (n < 2) seq[n] = 0; n++; drv_a(0, 1'b0, 1'b0, '0, '0); end
        if (ba.ack1) begin if (n < 2) seq[n] = 1; n++; drv_a(1, 1'b0, 1'b0, '0, '0); end
      end
      chk("tbl_first", seq[0], tbl[i].first);
      chk("tbl_second", seq[1], tbl[i].second);
      chk("tbl_rdata0", ba.rdata0, tbl[i].rd0);
      chk("tbl_rdata1", ba.rdata1, tbl[i].rd1);
    end

    // single read with exact latency
    wait_idle_a();
    drv_a(0, 1'b1, 1'b0, 32'h20, '0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("sr_mem_en", ba.mem_en, k == 1);
      if (k == 1) begin chk("sr_addr", ba.mem_addr, 32'h20); chk("sr_we", ba.mem_we, 1'b0); end
      chk("sr_ack0", ba.ack0, k == LA + 2);
      chk("sr_ack1", ba.ack1, 1'b0);
      chk("sr_gnt1", ba.gnt[1], 1'b0);
      chk("sr_rdata0", ba.rdata0, (k >= LA + 2) ? 32'h22222222 : 32'h11111111);
      if (k == LA + 2) drv_a(0, 1'b0, 1'b0, '0, '0);
      if (k == LA + 3) chk("sr_busy_end", ba.busy, 1'b0);
    end

    // late arrival: port 1 raised during port 0's WAIT is issued 2 cycles after ack0
    wait_idle_a();
    drv_a(0, 1'b1, 1'b0, 32'h10, '0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("late_mem_en", ba.mem_en, k == 1 || k == LA + 4);
      if (k == LA + 4) begin
        chk("late_gnt", ba.gnt, 2'b10);
        chk("late_addr", ba.mem_addr, 32'h10);
      end
      chk("late_ack0", ba.ack0, k == LA + 2);
      chk("late_ack1", ba.ack1, k == 2 * LA + 5);
      if (k == 2) drv_a(1, 1'b1, 1'b0, 32'h10, '0);
      if (k == LA + 2) drv_a(0, 1'b0, 1'b0, '0, '0);
      if (k == 2 * LA + 5) begin
        chk("late_rdata1", ba.rdata1, 32'h11111111);
        drv_a(1, 1'b0, 1'b0, '0, '0);
      end
    end

    // reset mid-WAIT with the request still held
    wait_idle_a();
    drv_a(0, 1'b1, 1'b0, 32'h20, '0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk("mr_ack0", ba.ack0, 1'b0);
        chk("mr_gnt", ba.gnt, 2'b00);
        chk("mr_busy", ba.busy, 1'b0);
        chk("mr_rdata0", ba.rdata0, 32'h0);
        chk("mr_rdata1", ba.rdata1, 32'h0);
        rst = 1'b0;
      end
      chk("mr_mem_en", ba.mem_en, k == 1 || k == 4);
      if (k >= 4) chk("mr_ack0_re", ba.ack0, k == LA + 5);
      if (k == LA + 5) begin
        chk("mr_rdata0_re", ba.rdata0, 32'h22222222);
        drv_a(0, 1'b0, 1'b0, '0, '0);
      end
      if (k == 2) rst = 1'b1;
    end

    // latency 15 boundary
    seq_b(1'b1, 32'h30, 32'hA5A55A5A, 32'h0);
    @(negedge clk);
    seq_b(1'b0, 32'h30, 32'h0, 32'hA5A55A5A);

    // random traffic vs transaction-schedule model
    do_reset();
    for (int p = 0; p < 2; p++) begin
      pr[p] = 1'b0; pwe[p] = 1'b0; pad[p] = 32'h40; pwd[p] = '0; rref[p] = '0;
    end
    for (int i = 0; i < 16; i++) refmem[i] = '0;
    m_act = 1'b0; m_own = 1'b0; m_last = 1'b1; m_d = 0; m_ni = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      en_exp  = m_act && (c == m_d + 1);
      ack_exp = m_act && (c == m_d + 2 + LA);
      inx     = m_act && (c >= m_d + 1) && (c <= m_d + 2 + LA);
      if (en_exp && pwe[m_own]) refmem[pad[m_own][3:0]] = pwd[m_own];
      if (ack_exp && !pwe[m_own]) rref[m_own] = refmem[pad[m_own][3:0]];
      chk("rnd_mem_en", ba.mem_en, en_exp);
      if (en_exp) begin
        chk("rnd_mem_addr", ba.mem_addr, pad[m_own]);
        chk("rnd_mem_we", ba.mem_we, pwe[m_own]);
        if (pwe[m_own]) chk("rnd_mem_wdata", ba.mem_wdata, pwd[m_own]);
      end
      chk("rnd_gnt", ba.gnt, inx ? (m_own ? 2'b10 : 2'b01) : 2'b00);
      chk("rnd_busy", ba.busy, inx);
      chk("rnd_ack0", ba.ack0, ack_exp && !m_own);
      chk("rnd_ack1", ba.ack1, ack_exp && m_own);
      chk("rnd_rdata0", ba.rdata0, rref[0]);
      chk("rnd_rdata1", ba.rdata1, rref[1]);
      for (int p = 0; p < 2; p++) begin
        just = ack_exp && (int'(m_own) == p);
        if (just ? ($urandom_range(1, 0) == 1) : (!pr[p] && $urandom_range(99, 0) < 40)) begin
          pr[p] = 1'b1; pwe[p] = 1'($urandom_range(1, 0));
          pad[p] = 32'h40 + 32'($urandom_range(15, 0)); pwd[p] = $urandom;
        end else if (just) begin
          pr[p] = 1'b0;
        end
      end
      if (ack_exp) m_act = 1'b0;
      drv_a(0, pr[0], pwe[0], pad[0], pwd[0]);
      drv_a(1, pr[1], pwe[1], pad[1], pwd[1]);
      if (!m_act && c >= m_ni && (pr[0] || pr[1])) begin
        m_own  = (pr[0] && pr[1]) ? ~m_last : pr[1];
        m_last = m_own;
        m_act  = 1'b1;
        m_d    = c;
        m_ni   = c + 3 + LA;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
